// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register file with scoreboard.
//   DEF_WIDTH  : default data width of each register
//   DEF_ADDR_W : default address width (depth = 2**DEF_ADDR_W)
//   ZERO_IDX   : index of the hard-wired zero register
//   busy_vec_t : one busy bit per register at the default geometry
package regfile_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_IDX   = 0;

   typedef logic [2**DEF_ADDR_W-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_word.sv
// regfile_word
// One storage word of the register file: a falling-edge register with a
// load enable and a parametrised asynchronous reset value.
// Ports:
//   clk   : clock, state updates on the falling edge
//   rst_n : asynchronous active-low reset, loads RESET_VALUE
//   load  : load enable
//   d     : data in
//   q     : stored word
module regfile_word
   import regfile_pkg::*;
#(
   parameter int                WIDTH       = DEF_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VALUE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_scb.sv
// regfile_scb
// Register file with two registered read ports, one write port and a
// per-register busy scoreboard. All state changes on the falling edge of CLK.
// Optional build macro: REGFILE_BYPASS_EN -- a same-edge read of WR_ADDR
// returns WR_DATA, and BUSYn is masked while a write to RD_ADDRn is present.
// Ports:
//   CLK, RESET               : clock (falling edge active), async active-low reset
//   WR_EN, WR_ADDR, WR_DATA  : write port; a write also clears busy[WR_ADDR]
//   RD_EN, RD_ADDR1/2        : read request for both ports
//   RD_DATA1/2, RD_VALID     : registered read data and its one-cycle strobe
//   RSV_EN, RSV_ADDR         : reserve port; sets busy[RSV_ADDR]
//   BUSY1, BUSY2             : combinational busy status of RD_ADDR1/2
// Read handshake: there is no ready; the consumer asserts RD_EN only when it
// accepts the result, and RD_VALID pulses for exactly the cycle after each
// sampled RD_EN. The block never stalls; the consumer gates RD_EN with BUSYn.
module regfile_scb
   import regfile_pkg::*;
#(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter int               ADDR_W      = DEF_ADDR_W,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               ZERO_REG    = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [WIDTH-1:0]  WR_DATA,
   input  logic              RD_EN,
   input  logic [ADDR_W-1:0] RD_ADDR1,
   input  logic [ADDR_W-1:0] RD_ADDR2,
   output logic [WIDTH-1:0]  RD_DATA1,
   output logic [WIDTH-1:0]  RD_DATA2,
   output logic              RD_VALID,
   input  logic              RSV_EN,
   input  logic [ADDR_W-1:0] RSV_ADDR,
   output logic              BUSY1,
   output logic              BUSY2
);

   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

   logic [WIDTH-1:0] word_q [DEPTH];
   logic [DEPTH-1:0] busy;
   logic             wr_ok;
   logic             rsv_ok;
   logic [WIDTH-1:0] rd_word1;
   logic [WIDTH-1:0] rd_word2;

   // Writes and reserves aimed at the zero register are dropped here, so
   // neither the storage nor the scoreboard ever sees them.
   assign wr_ok  = WR_EN  && !(ZERO_REG && (WR_ADDR  == ZADDR));
   assign rsv_ok = RSV_EN && !(ZERO_REG && (RSV_ADDR == ZADDR));

   // Storage: one word per register; the zero register has no flop at all.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      if (ZERO_REG && (i == ZERO_IDX)) begin : g_zero
         assign word_q[i] = '0;
      end else begin : g_reg
         regfile_word #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_word (
            .clk   (CLK),
            .rst_n (RESET),
            .load  (wr_ok && (WR_ADDR == IDX)),
            .d     (WR_DATA),
            .q     (word_q[i])
         );
      end
   end

   // Scoreboard. The reserve is applied after the clear so that a same-edge
   // write and reserve to one address leaves it busy (new producer wins).
   always_ff @(negedge CLK or negedge RESET) begin
      if (!RESET) begin
         busy <= '0;
      end else begin
         if (wr_ok) begin
            busy[WR_ADDR] <= 1'b0;
         end
         if (rsv_ok) begin
            busy[RSV_ADDR] <= 1'b1;
         end
      end
   end

   // Read mux with optional write-to-read forwarding. wr_ok already excludes
   // the zero register, so forwarding can never make it non-zero.
   always_comb begin
      rd_word1 = word_q[RD_ADDR1];
      rd_word2 = word_q[RD_ADDR2];
      BUSY1    = busy[RD_ADDR1];
      BUSY2    = busy[RD_ADDR2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (WR_ADDR == RD_ADDR1)) begin
         rd_word1 = WR_DATA;
      end
      if (wr_ok && (WR_ADDR == RD_ADDR2)) begin
         rd_word2 = WR_DATA;
      end
      // The write in flight completes the pending value, so do not stall on it.
      if (WR_EN && (WR_ADDR == RD_ADDR1)) begin
         BUSY1 = 1'b0;
      end
      if (WR_EN && (WR_ADDR == RD_ADDR2)) begin
         BUSY2 = 1'b0;
      end
`endif
   end

   always_ff @(negedge CLK or negedge RESET) begin
      if (!RESET) begin
         RD_DATA1 <= '0;
         RD_DATA2 <= '0;
         RD_VALID <= 1'b0;
      end else begin
         RD_VALID <= RD_EN;
         if (RD_EN) begin
            RD_DATA1 <= rd_word1;
            RD_DATA2 <= rd_word2;
         end
      end
   end

endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb
// Directed bench for regfile_scb with RESET_VALUE = 32'h0000_00FF and a
// hard-wired zero register. Inputs change shortly after the rising edge, the
// DUT updates on the falling edge, and outputs are checked after the next
// rising edge. Expected values that depend on REGFILE_BYPASS_EN follow the
// same macro.
module tb_regfile_scb;

   localparam logic [31:0] RV = 32'h0000_00FF;

   logic        CLK;
   logic        RESET;
   logic        WR_EN;
   logic [4:0]  WR_ADDR;
   logic [31:0] WR_DATA;
   logic        RD_EN;
   logic [4:0]  RD_ADDR1;
   logic [4:0]  RD_ADDR2;
   logic [31:0] RD_DATA1;
   logic [31:0] RD_DATA2;
   logic        RD_VALID;
   logic        RSV_EN;
   logic [4:0]  RSV_ADDR;
   logic        BUSY1;
   logic        BUSY2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        se;
      logic [4:0]  sa;
      logic        exp_v;
      logic [31:0] exp_d1;
      logic [31:0] exp_d2;
      logic        exp_b1;
      logic        exp_b2;
   } vec_t;

   vec_t vecs [15];

   regfile_scb #(
      .WIDTH       (32),
      .ADDR_W      (5),
      .RESET_VALUE (RV),
      .ZERO_REG    (1'b1)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .WR_EN    (WR_EN),
      .WR_ADDR  (WR_ADDR),
      .WR_DATA  (WR_DATA),
      .RD_EN    (RD_EN),
      .RD_ADDR1 (RD_ADDR1),
      .RD_ADDR2 (RD_ADDR2),
      .RD_DATA1 (RD_DATA1),
      .RD_DATA2 (RD_DATA2),
      .RD_VALID (RD_VALID),
      .RSV_EN   (RSV_EN),
      .RSV_ADDR (RSV_ADDR),
      .BUSY1    (BUSY1),
      .BUSY2    (BUSY2)
   );

   // clock: rising edges at 10, 20, ...; falling (active) edges at 5, 15, ...
   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_strobes();
      WR_EN  = 1'b0;
      RD_EN  = 1'b0;
      RSV_EN = 1'b0;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      WR_EN    = v.we;
      WR_ADDR  = v.wa;
      WR_DATA  = v.wd;
      RD_EN    = v.re;
      RD_ADDR1 = v.a1;
      RD_ADDR2 = v.a2;
      RSV_EN   = v.se;
      RSV_ADDR = v.sa;
      @(negedge CLK);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d rd_valid", idx), 32'(RD_VALID), 32'(v.exp_v));
      chk($sformatf("v%0d rd_data1", idx), RD_DATA1, v.exp_d1);
      chk($sformatf("v%0d rd_data2", idx), RD_DATA2, v.exp_d2);
      // Drop strobes so BUSYn shows the stored scoreboard bit alone.
      clear_strobes();
      #1;
      chk($sformatf("v%0d busy1", idx), 32'(BUSY1), 32'(v.exp_b1));
      chk($sformatf("v%0d busy2", idx), 32'(BUSY2), 32'(v.exp_b2));
   endtask

   initial begin
      logic [31:0] byp_d;
      logic        byp_b;
`ifdef REGFILE_BYPASS_EN
      byp_d = 32'd2;
      byp_b = 1'b0;
`else
      byp_d = 32'd1;
      byp_b = 1'b1;
`endif
      //          we    wa     wd            re    a1     a2     se    sa     v     d1            d2            b1    b2
      vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  1'b0, 5'd0,  1'b1, RV,           32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7,  5'd0,  1'b0, 5'd0,  1'b0, RV,           32'h0,        1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  1'b0, 5'd0,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd7,  1'b1, 5'd5,  1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd7,  1'b1, 5'd7,  1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
      vecs[8]  = '{1'b1, 5'd5,  32'hAAAA5555, 1'b0, 5'd5,  5'd7,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
      vecs[9]  = '{1'b1, 5'd5,  32'h5555AAAA, 1'b0, 5'd5,  5'd7,  1'b1, 5'd5,  1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd7,  1'b0, 5'd0,  1'b1, 32'h5555AAAA, 32'hDEADBEEF, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 5'd7,  32'h00000077, 1'b0, 5'd5,  5'd7,  1'b0, 5'd0,  1'b0, 32'h5555AAAA, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 5'd9,  32'd1,        1'b0, 5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 32'h5555AAAA, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 5'd9,  32'd2,        1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  1'b1, byp_d,        byp_d,        1'b0, 1'b0};
      vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd2,  1'b0, 5'd0,  1'b1, 32'd2,        RV,           1'b0, 1'b0};

      // reset
      RESET    = 1'b0;
      clear_strobes();
      WR_ADDR  = '0;
      WR_DATA  = '0;
      RD_ADDR1 = 5'd3;
      RD_ADDR2 = 5'd0;
      RSV_ADDR = '0;
      #12;
      chk("reset rd_data1", RD_DATA1, 32'h0);
      chk("reset rd_data2", RD_DATA2, 32'h0);
      chk("reset rd_valid", 32'(RD_VALID), 32'h0);
      chk("reset busy1", 32'(BUSY1), 32'h0);
      chk("reset busy2", 32'(BUSY2), 32'h0);
      #10;
      RESET = 1'b1;
      @(posedge CLK);
      #2;

      for (int i = 0; i < 15; i++) begin
         apply_vec(i, vecs[i]);
      end

      // BUSY masking while a write to the read address is present.
      RSV_EN   = 1'b1;
      RSV_ADDR = 5'd11;
      RD_ADDR1 = 5'd11;
      RD_ADDR2 = 5'd0;
      @(negedge CLK);
      @(posedge CLK);
      #1;
      clear_strobes();
      #1;
      chk("rsv11 busy1", 32'(BUSY1), 32'h1);
      WR_EN   = 1'b1;
      WR_ADDR = 5'd11;
      WR_DATA = 32'h0BAD_F00D;
      #1;
      chk("bypass busy1", 32'(BUSY1), 32'(byp_b));
      WR_EN = 1'b0;
      #1;
      chk("busy1 after wr drop", 32'(BUSY1), 32'h1);

      // Reset between edges after reads and reserves.
      RD_EN    = 1'b1;
      RD_ADDR1 = 5'd11;
      RD_ADDR2 = 5'd12;
      RSV_EN   = 1'b1;
      RSV_ADDR = 5'd12;
      @(negedge CLK);
      #2;
      clear_strobes();
      #1;
      chk("pre-rst rd_valid", 32'(RD_VALID), 32'h1);
      chk("pre-rst rd_data1", RD_DATA1, RV);
      chk("pre-rst busy1", 32'(BUSY1), 32'h1);
      chk("pre-rst busy2", 32'(BUSY2), 32'h1);
      RESET = 1'b0;
      #1;
      chk("mid-rst rd_data1", RD_DATA1, 32'h0);
      chk("mid-rst rd_data2", RD_DATA2, 32'h0);
      chk("mid-rst rd_valid", 32'(RD_VALID), 32'h0);
      chk("mid-rst busy1", 32'(BUSY1), 32'h0);
      chk("mid-rst busy2", 32'(BUSY2), 32'h0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      #1;

      // Storage went back to RESET_VALUE too.
      apply_vec(100, '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 1'b0, 5'd0, 1'b1, RV, RV, 1'b0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
